hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Generates the stall (hold) and flush (bubble) enables for the F/D, D/E, E/M and M/W pipeline registers.
- Generates operand-forwarding selects for the execute stage.
- Runs a wait-state FSM that freezes the pipeline while a multi-cycle data-memory access in the M stage is outstanding, with timeout and halt-on-error.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_forward_unit.sv | 29 ++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing control slice.
package pipe_ctrl_pkg;

  // Default number of WAIT cycles tolerated before a data-memory access is declared dead.
  localparam int DEF_MEM_TIMEOUT = 64;

  // Execute-stage operand source select.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  // Data-memory wait-state controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand forwarding select for one execute-stage source register.
// The M stage holds the younger result, so it wins over W; x0 is never forwarded.
module forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic                  regWriteM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regWriteW,
  output fwd_sel_t              fwdSel
);

  logic hitM;
  logic hitW;

  assign hitM = regWriteM && (rdM != '0) && (rdM == rsE);
  assign hitW = regWriteW && (rdW != '0) && (rdW == rsE);

  // Pick the youngest in-flight producer of rsE.
  always_comb begin
    fwdSel = FWD_REG;
    if (hitM)      fwdSel = FWD_M;
    else if (hitW) fwdSel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: stall/flush enables, forwarding selects,
// data-memory wait-state FSM with timeout, and a saturating stall counter.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1D_i,
  input  logic [REG_ADDR_W-1:0] rs2D_i,
  input  logic [REG_ADDR_W-1:0] rs1E_i,
  input  logic [REG_ADDR_W-1:0] rs2E_i,
  input  logic [REG_ADDR_W-1:0] rdE_i,
  input  logic                  regWriteE_i,
  input  logic                  resultSRCE_i,
  input  logic [REG_ADDR_W-1:0] rdM_i,
  input  logic                  regWriteM_i,
  input  logic [REG_ADDR_W-1:0] rdW_i,
  input  logic                  regWriteW_i,
  input  logic                  branchTakenE_i,
  input  logic                  memAccessM_i,
  input  logic                  memReadyM_i,
  output logic                  stallF_o,
  output logic                  stallD_o,
  output logic                  stallE_o,
  output logic                  stallM_o,
  output logic                  flushD_o,
  output logic                  flushE_o,
  output logic                  flushW_o,
  output logic [1:0]            forwardAE_o,
  output logic [1:0]            forwardBE_o,
  output logic                  memError_o,
  output logic [CNT_W-1:0]      stallCount_o
);

  // A timeout of 1 still needs a 1-bit timer to hold the compare value 0.
  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(MEM_TIMEOUT - 1);

  mem_state_t       state;
  mem_state_t       nextState;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timerNext;
  logic             memStall;
  logic             luHaz;
  logic [CNT_W-1:0] stallCnt;
  fwd_sel_t         fwdA;
  fwd_sel_t         fwdB;

  // Wait-state register and timeout timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= nextState;
      timer <= timerNext;
    end
  end

  // Next state and memory stall. The stall is raised in the same cycle the
  // access is seen not-ready, and dropped in the cycle ready arrives.
  always_comb begin
    nextState = state;
    timerNext = timer;
    memStall  = 1'b0;
    unique case (state)
      IDLE: begin
        if (memAccessM_i && !memReadyM_i) begin
          memStall  = 1'b1;
          nextState = WAIT;
          timerNext = '0;
        end
      end
      WAIT: begin
        if (memReadyM_i) begin
          nextState = IDLE;
        end else begin
          memStall = 1'b1;
          if (timer == TIMER_LAST) nextState = ERR;
          else                     timerNext = timer + 1'b1;
        end
      end
      ERR: begin
        memStall = 1'b1;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Load in E whose destination feeds an instruction in D; x0 never hazards.
  assign luHaz = resultSRCE_i && regWriteE_i && (rdE_i != '0) &&
                 ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

  // Stall/flush priority: memory freeze, then taken branch, then load-use.
  always_comb begin
    stallF_o = 1'b0;
    stallD_o = 1'b0;
    stallE_o = 1'b0;
    stallM_o = 1'b0;
    flushD_o = 1'b0;
    flushE_o = 1'b0;
    flushW_o = 1'b0;
    if (!rst) begin
      if (memStall) begin
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        stallE_o = 1'b1;
        stallM_o = 1'b1;
        flushW_o = 1'b1;
      end else if (branchTakenE_i) begin
        // The load-use victim in D is wrong-path, so no stall is needed.
        flushD_o = 1'b1;
        flushE_o = 1'b1;
      end else if (luHaz) begin
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        flushE_o = 1'b1;
      end
    end
  end

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
    .rsE       (rs1E_i),
    .rdM       (rdM_i),
    .regWriteM (regWriteM_i),
    .rdW       (rdW_i),
    .regWriteW (regWriteW_i),
    .fwdSel    (fwdA)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
    .rsE       (rs2E_i),
    .rdM       (rdM_i),
    .regWriteM (regWriteM_i),
    .rdW       (rdW_i),
    .regWriteW (regWriteW_i),
    .fwdSel    (fwdB)
  );

  // Forwarding is independent of stalls; only reset masks it.
  assign forwardAE_o = rst ? 2'b00 : fwdA;
  assign forwardBE_o = rst ? 2'b00 : fwdB;

  assign memError_o = (state == ERR);

  // Saturating count of cycles the front end was held.
  always_ff @(posedge clk) begin
    if (rst)                         stallCnt <= '0;
    else if (stallF_o && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
  end

  assign stallCount_o = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a per-cycle reference model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int MT = 64;
  localparam int CW = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          regWriteE, resultSRCE, regWriteM, regWriteW;
  logic          branchTakenE, memAccessM, memReadyM;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0]    forwardAE, forwardBE;
  logic          memError;
  logic [CW-1:0] stallCount;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b1;

  // Reference model state: outstanding-wait flag, wait cycles spent, dead flag, stall cycles.
  bit     mWaiting = 1'b0;
  int     mWaitCnt = 0;
  bit     mErr     = 1'b0;
  longint mCnt     = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1D_i         (rs1D),
    .rs2D_i         (rs2D),
    .rs1E_i         (rs1E),
    .rs2E_i         (rs2E),
    .rdE_i          (rdE),
    .regWriteE_i    (regWriteE),
    .resultSRCE_i   (resultSRCE),
    .rdM_i          (rdM),
    .regWriteM_i    (regWriteM),
    .rdW_i          (rdW),
    .regWriteW_i    (regWriteW),
    .branchTakenE_i (branchTakenE),
    .memAccessM_i   (memAccessM),
    .memReadyM_i    (memReadyM),
    .stallF_o       (stallF),
    .stallD_o       (stallD),
    .stallE_o       (stallE),
    .stallM_o       (stallM),
    .flushD_o       (flushD),
    .flushE_o       (flushE),
    .flushW_o       (flushW),
    .forwardAE_o    (forwardAE),
    .forwardBE_o    (forwardBE),
    .memError_o     (memError),
    .stallCount_o   (stallCount)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected {stallF,stallD,stallE,stallM,flushD,flushE,flushW} from the rules.
  function automatic logic [6:0] expCtl();
    bit ms, lu;
    ms = mErr || (!memReadyM && (mWaiting || memAccessM));
    lu = resultSRCE && regWriteE && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
    if (rst)               return 7'b0000000;
    else if (ms)           return 7'b1111001;
    else if (branchTakenE) return 7'b0000110;
    else if (lu)           return 7'b1100010;
    else                   return 7'b0000000;
  endfunction

  function automatic logic [1:0] expFwd(input logic [AW-1:0] rs);
    if (rst)                                   return 2'b00;
    if (regWriteM && rdM != 0 && rdM == rs)    return 2'b10;
    if (regWriteW && rdW != 0 && rdW == rs)    return 2'b01;
    return 2'b00;
  endfunction

  // Advance the model on each clock edge.
  always @(posedge clk) begin
    logic [6:0] c;
    c = expCtl();
    if (rst) begin
      mWaiting = 1'b0; mWaitCnt = 0; mErr = 1'b0; mCnt = 0;
    end else begin
      if (c[6] && mCnt < CMAX) mCnt = mCnt + 1;
      if (!mErr) begin
        if (mWaiting) begin
          if (memReadyM)              mWaiting = 1'b0;
          else if (mWaitCnt == MT-1)  begin mErr = 1'b1; mWaiting = 1'b0; end
          else                        mWaitCnt = mWaitCnt + 1;
        end else if (memAccessM && !memReadyM) begin
          mWaiting = 1'b1; mWaitCnt = 0;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic [6:0] c;
    if (cmpEn) begin
      c = expCtl();
      chk("cyc_stallF",  stallF,  c[6]);
      chk("cyc_stallD",  stallD,  c[5]);
      chk("cyc_stallE",  stallE,  c[4]);
      chk("cyc_stallM",  stallM,  c[3]);
      chk("cyc_flushD",  flushD,  c[2]);
      chk("cyc_flushE",  flushE,  c[1]);
      chk("cyc_flushW",  flushW,  c[0]);
      chk("cyc_fwdA",    forwardAE, expFwd(rs1E));
      chk("cyc_fwdB",    forwardBE, expFwd(rs2E));
      chk("cyc_memErr",  memError, mErr);
      chk("cyc_count",   stallCount, mCnt);
    end
  end

  task automatic idleIn();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regWriteE = 0; resultSRCE = 0; regWriteM = 0; regWriteW = 0;
    branchTakenE = 0; memAccessM = 0; memReadyM = 0;
  endtask

  task automatic nextCyc();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idleIn();
    // Reset with a load-use and a forwarding match presented: all masked.
    resultSRCE = 1; regWriteE = 1; rdE = 5; rs1D = 5;
    regWriteM = 1; rdM = 7; rs2E = 7;
    nextCyc(); nextCyc();
    chk("rst_stallF", stallF, 0);
    chk("rst_flushE", flushE, 0);
    chk("rst_fwdB",   forwardBE, 0);
    chk("rst_count",  stallCount, 0);
    chk("rst_memErr", memError, 0);

    // Load-use on rs1.
    rst = 0; idleIn();
    resultSRCE = 1; regWriteE = 1; rdE = 5; rs1D = 5; #1;
    chk("lu_stallF", stallF, 1);
    chk("lu_stallD", stallD, 1);
    chk("lu_flushE", flushE, 1);
    chk("lu_stallE", stallE, 0);
    nextCyc(); idleIn(); #1;
    chk("lu_count", stallCount, 1);

    // Load into x0 never hazards.
    resultSRCE = 1; regWriteE = 1; rdE = 0; rs1D = 0; #1;
    chk("x0_stallF", stallF, 0);
    chk("x0_flushE", flushE, 0);
    nextCyc(); idleIn();

    // Branch beats load-use.
    resultSRCE = 1; regWriteE = 1; rdE = 9; rs2D = 9; branchTakenE = 1; #1;
    chk("br_flushD", flushD, 1);
    chk("br_flushE", flushE, 1);
    chk("br_stallF", stallF, 0);
    chk("br_stallD", stallD, 0);
    nextCyc(); idleIn();

    // Forwarding priority and x0.
    rdM = 7; rdW = 7; rs2E = 7; regWriteM = 1; regWriteW = 1; #1;
    chk("fwd_M", forwardBE, 2'b10);
    regWriteM = 0; #1;
    chk("fwd_W", forwardBE, 2'b01);
    rdM = 0; rdW = 0; rs1E = 0; regWriteM = 1; #1;
    chk("fwd_x0", forwardAE, 2'b00);
    nextCyc(); idleIn();

    // Three-cycle memory wait, with a branch presented mid-freeze.
    memAccessM = 1; memReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      branchTakenE = (i == 1); #1;
      chk("mw_stallF", stallF, 1);
      chk("mw_stallM", stallM, 1);
      chk("mw_flushW", flushW, 1);
      chk("mw_flushD", flushD, 0);
      nextCyc();
    end
    branchTakenE = 0; memReadyM = 1; #1;
    chk("mw_rdy_stallF", stallF, 0);
    chk("mw_rdy_flushW", flushW, 0);
    nextCyc(); idleIn(); #1;
    chk("mw_count", stallCount, 4);
    chk("mw_idle_stall", stallF, 0);
    nextCyc();

    // Timeout into ERR.
    memAccessM = 1; memReadyM = 0;
    n = 0;
    while (!memError && n < 200) begin nextCyc(); n++; end
    chk("to_cycles", n, MT + 1);
    memAccessM = 0; memReadyM = 1; #1;
    chk("err_stallF", stallF, 1);
    chk("err_stallM", stallM, 1);
    chk("err_memErr", memError, 1);

    // Counter saturates while frozen in ERR.
    repeat (66000) @(posedge clk);
    #1;
    chk("sat_count", stallCount, CMAX);

    // Reset clears everything.
    rst = 1; nextCyc();
    chk("rst2_memErr", memError, 0);
    chk("rst2_count",  stallCount, 0);
    chk("rst2_stallF", stallF, 0);
    rst = 0; idleIn(); #1;
    chk("post_rst_stallF", stallF, 0);
    nextCyc();

    cmpEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
